// File: rtl/imem_dmem_arbiter.sv
// Arbitrates fetch (IF) and load/store (DM) onto one single-port memory, one read outstanding.
// Optional IF anti-starvation guard enabled by defining ARB_STARVE_GUARD_EN.
module imem_dmem_arbiter #(
  parameter int unsigned AW         = 32,
  parameter int unsigned DW         = 32,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          if_req_i,
  input  logic [AW-1:0] if_addr_i,
  input  logic          if_kill_i,
  output logic          if_gnt_o,
  output logic          if_rvalid_o,
  output logic [DW-1:0] if_rdata_o,
  input  logic          dm_req_i,
  input  logic          dm_we_i,
  input  logic [AW-1:0] dm_addr_i,
  input  logic [DW-1:0] dm_wdata_i,
  output logic          dm_gnt_o,
  output logic          dm_rvalid_o,
  output logic [DW-1:0] dm_rdata_o,
  output logic          mem_req_o,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_wdata_o,
  input  logic          mem_gnt_i,
  input  logic          mem_rvalid_i,
  input  logic [DW-1:0] mem_rdata_i
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RD_IF = 2'd1;
  localparam logic [1:0] ST_RD_DM = 2'd2;

  logic [1:0] state_q, state_d;
  logic       kill_pend_q, kill_pend_d;
  logic       slot, force_if, pick_dm, pick_if, in_rd_if, in_rd_dm;

  assign in_rd_if = (state_q == ST_RD_IF);
  assign in_rd_dm = (state_q == ST_RD_DM);
  // A slot is any IDLE cycle, or the return cycle of an outstanding read.
  assign slot     = (state_q == ST_IDLE) | ((in_rd_if | in_rd_dm) & mem_rvalid_i);

`ifdef ARB_STARVE_GUARD_EN
  localparam int unsigned CW = $clog2(STARVE_MAX + 1);
  logic [CW-1:0] starve_cnt_q, starve_cnt_d;

  assign force_if = (starve_cnt_q == CW'(STARVE_MAX)) & if_req_i;

  // Consecutive DM grants that left a fetch waiting; saturates at STARVE_MAX.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (if_gnt_o || !if_req_i) begin
      starve_cnt_d = '0;
    end else if (dm_gnt_o && (starve_cnt_q != CW'(STARVE_MAX))) begin
      starve_cnt_d = starve_cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) starve_cnt_q <= '0;
    else       starve_cnt_q <= starve_cnt_d;
  end
`else
  logic unused_starve_max;
  assign unused_starve_max = (STARVE_MAX == 0);
  assign force_if = 1'b0;
`endif

  assign pick_dm = !rst_i & slot & dm_req_i & !force_if;
  assign pick_if = !rst_i & slot & if_req_i & !pick_dm;

  // Memory request mux and same-cycle grants / response routing.
  always_comb begin
    mem_req_o   = pick_dm | pick_if;
    mem_we_o    = pick_dm & dm_we_i;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (pick_dm) begin
      mem_addr_o  = dm_addr_i;
      mem_wdata_o = dm_wdata_i;
    end else if (pick_if) begin
      mem_addr_o  = if_addr_i;
    end
    dm_gnt_o    = pick_dm & mem_gnt_i;
    if_gnt_o    = pick_if & mem_gnt_i;
    dm_rvalid_o = !rst_i & in_rd_dm & mem_rvalid_i;
    if_rvalid_o = !rst_i & in_rd_if & mem_rvalid_i & !kill_pend_q & !if_kill_i;
    dm_rdata_o  = dm_rvalid_o ? mem_rdata_i : '0;
    if_rdata_o  = if_rvalid_o ? mem_rdata_i : '0;
  end

  // Next state and kill tracking.
  always_comb begin
    state_d     = state_q;
    kill_pend_d = kill_pend_q;
    if (dm_gnt_o) begin
      state_d = dm_we_i ? ST_IDLE : ST_RD_DM;
    end else if (if_gnt_o) begin
      state_d = ST_RD_IF;
    end else if ((in_rd_if | in_rd_dm) & mem_rvalid_i) begin
      state_d = ST_IDLE;
    end
    if (if_gnt_o) begin
      kill_pend_d = if_kill_i;
    end else if (in_rd_if & mem_rvalid_i) begin
      kill_pend_d = 1'b0;
    end else if (in_rd_if & if_kill_i) begin
      kill_pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      kill_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      kill_pend_q <= kill_pend_d;
    end
  end

endmodule
